// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and FSM encoding for the FIR coefficient path
package fir_pkg;

  // Defaults shared with the filter datapath
  localparam int DEF_N_TAPS  = 74;
  localparam int DEF_COEF_W  = 8;
  localparam int DEF_ADDR_W  = 7;
  localparam int DEF_TIMEOUT = 1024;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef logic [2:0] fsm_state_t;

  localparam fsm_state_t ST_SYNC = 3'd0;
  localparam fsm_state_t ST_LEN  = 3'd1;
  localparam fsm_state_t ST_DATA = 3'd2;
  localparam fsm_state_t ST_CHK  = 3'd3;
  localparam fsm_state_t ST_FILL = 3'd4;
  localparam fsm_state_t ST_SWAP = 3'd5;

endpackage

// File: rtl/fir_ld_timeout.sv
// rtl/fir_ld_timeout.sv - idle-cycle counter that flags a stalled frame
module fir_ld_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;

  // An accepted byte always wins over expiry, so a byte on the last idle cycle is not lost
  assign expired = enable & ~clear & (cnt_q == CNT_W'(TIMEOUT - 1));

  // Count idle cycles while a frame is open; restart on any byte or outside a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || !enable || expired) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fir_coef_loader.sv
// rtl/fir_coef_loader.sv - framed byte stream to double-buffered FIR coefficient RAM
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int N_TAPS  = DEF_N_TAPS,
  parameter int COEF_W  = DEF_COEF_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              coef_we,
  output logic              coef_bank,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [COEF_W-1:0] coef_data,
  output logic              active_bank,
  output logic              coefs_valid,
  output logic              load_busy,
  output logic              load_err
);

  fsm_state_t        state_q;
  fsm_state_t        state_d;
  logic              rdy_en_q;
  logic [ADDR_W-1:0] n_q;
  logic [ADDR_W-1:0] idx_q;
  logic [7:0]        sum_q;
  logic [7:0]        chk_sum;
  logic              take;
  logic              len_bad;
  logic              last_data;
  logic              last_fill;
  logic              n_full;
  logic              abort;
  logic              tmo_en;
  logic              tmo_expired;

  assign take      = in_valid & in_ready;
  assign len_bad   = (in_data == 8'd0) || (in_data > 8'(N_TAPS));
  assign chk_sum   = sum_q + in_data;
  assign last_data = (idx_q == n_q - ADDR_W'(1));
  assign last_fill = (idx_q == ADDR_W'(N_TAPS - 1));
  assign n_full    = (n_q == ADDR_W'(N_TAPS));
  assign tmo_en    = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);

  fir_ld_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (take),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  // Hold in_ready low while in reset; it rises on the first clock after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and abort decision; 0xA5 only matters while hunting for sync
  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (take && in_data == SYNC_BYTE) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (tmo_expired) begin
          abort = 1'b1;
        end else if (take) begin
          if (len_bad) abort = 1'b1;
          else         state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tmo_expired)            abort   = 1'b1;
        else if (take && last_data) state_d = ST_CHK;
      end
      ST_CHK: begin
        if (tmo_expired) begin
          abort = 1'b1;
        end else if (take) begin
          if (chk_sum != 8'd0) abort   = 1'b1;
          else if (n_full)     state_d = ST_SWAP;
          else                 state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (last_fill) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        state_d = ST_SYNC;
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
    if (abort) state_d = ST_SYNC;
  end

  // FSM outputs: back-pressure the source only while zero-filling or swapping
  always_comb begin
    in_ready  = 1'b0;
    load_busy = (state_q != ST_SYNC);
    case (state_q)
      ST_SYNC, ST_LEN, ST_DATA, ST_CHK: in_ready = rdy_en_q;
      default:                          in_ready = 1'b0;
    endcase
  end

  // Datapath: checksum, tap index, registered RAM write port and bank control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q         <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      coef_we     <= 1'b0;
      coef_bank   <= 1'b0;
      coef_addr   <= '0;
      coef_data   <= '0;
      active_bank <= 1'b0;
      coefs_valid <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      coef_we  <= 1'b0;
      load_err <= abort;
      case (state_q)
        ST_LEN: begin
          if (take && !len_bad) begin
            n_q   <= in_data[ADDR_W-1:0];
            sum_q <= in_data;
            idx_q <= '0;
          end
        end
        ST_DATA: begin
          if (take) begin
            coef_we   <= 1'b1;
            coef_bank <= ~active_bank;
            coef_addr <= idx_q;
            coef_data <= in_data[COEF_W-1:0];
            sum_q     <= sum_q + in_data;
            idx_q     <= idx_q + ADDR_W'(1);
          end
        end
        ST_FILL: begin
          coef_we   <= 1'b1;
          coef_bank <= ~active_bank;
          coef_addr <= idx_q;
          coef_data <= '0;
          idx_q     <= idx_q + ADDR_W'(1);
        end
        ST_SWAP: begin
          active_bank <= ~active_bank;
          coefs_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb/tb_fir_coef_loader.sv - directed self-checking bench for fir_coef_loader
module tb_fir_coef_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       coef_we;
  logic       coef_bank;
  logic [6:0] coef_addr;
  logic [7:0] coef_data;
  logic       active_bank;
  logic       coefs_valid;
  logic       load_busy;
  logic       load_err;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int err_cnt  = 0;
  logic [7:0] mem0 [0:127];
  logic [7:0] mem1 [0:127];

  fir_coef_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .coef_we     (coef_we),
    .coef_bank   (coef_bank),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .active_bank (active_bank),
    .coefs_valid (coefs_valid),
    .load_busy   (load_busy),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (coef_we === 1'b1) begin
      wr_cnt++;
      if (coef_bank) mem1[coef_addr] = coef_data;
      else           mem0[coef_addr] = coef_data;
    end
    if (load_err === 1'b1) err_cnt++;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 128; i++) begin
      mem0[i] = 8'hEE;
      mem1[i] = 8'hEE;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL send_accept: byte %02h not accepted, in_ready=%b required 1", b, in_ready);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (load_busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      failures++;
      $display("FAIL wait_done: load_busy=%b required 0 within 500 cycles", load_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    idle(3);
    checks++;
    if ({in_ready, coef_we, active_bank, coefs_valid, load_busy, load_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 000000",
               {in_ready, coef_we, active_bank, coefs_valid, load_busy, load_err});
    end
    rst_n = 1'b1;
    idle(1);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_short_frame();
    int w0, e0;
    clr_mem(); w0 = wr_cnt; e0 = err_cnt;
    send_q('{8'hA5, 8'h03, 8'h01});
    checks++;
    if ({coef_we, coef_bank, coef_addr, coef_data} !== {1'b1, 1'b1, 7'd0, 8'h01}) begin
      failures++;
      $display("FAIL latency1_write: we/bank/addr/data=%b/%b/%0d/%02h required 1/1/0/01",
               coef_we, coef_bank, coef_addr, coef_data);
    end
    send_q('{8'hFF, 8'h7F, 8'h7E});
    in_valid = 1'b0;
    wait_done(); idle(2);
    checks++;
    if (wr_cnt - w0 != 74) begin failures++; $display("FAIL t1_writes: got %0d required 74", wr_cnt - w0); end
    checks++;
    if ({mem1[0], mem1[1], mem1[2]} !== 24'h01FF7F) begin
      failures++; $display("FAIL t1_data: got %02h %02h %02h required 01 FF 7F", mem1[0], mem1[1], mem1[2]);
    end
    for (int i = 3; i < 74; i++) begin
      checks++;
      if (mem1[i] !== 8'h00) begin failures++; $display("FAIL t1_fill[%0d]: got %02h required 00", i, mem1[i]); end
    end
    checks++;
    if (mem0[0] !== 8'hEE) begin failures++; $display("FAIL t1_active_untouched: got %02h required EE", mem0[0]); end
    checks++;
    if ({active_bank, coefs_valid, in_ready} !== 3'b111) begin
      failures++; $display("FAIL t1_swap: bank/valid/ready=%b required 111", {active_bank, coefs_valid, in_ready});
    end
    checks++;
    if (err_cnt != e0) begin failures++; $display("FAIL t1_no_err: got %0d required 0", err_cnt - e0); end
  endtask

  task automatic test_bad_checksum();
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    send_q('{8'hA5, 8'h03, 8'h01, 8'hFF, 8'h7F, 8'h80});
    in_valid = 1'b0;
    wait_done(); idle(2);
    checks++;
    if (err_cnt - e0 != 1) begin failures++; $display("FAIL t2_err: got %0d pulses required 1", err_cnt - e0); end
    checks++;
    if ({active_bank, coefs_valid} !== 2'b11) begin
      failures++; $display("FAIL t2_no_swap: bank/valid=%b required 11", {active_bank, coefs_valid});
    end
    checks++;
    if (wr_cnt - w0 != 3) begin failures++; $display("FAIL t2_writes: got %0d required 3", wr_cnt - w0); end
  endtask

  task automatic test_bad_count();
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    send_q('{8'hA5, 8'h00});
    in_valid = 1'b0; idle(3);
    checks++;
    if (err_cnt - e0 != 1 || load_busy !== 1'b0) begin
      failures++; $display("FAIL t3_count0: err=%0d busy=%b required 1 0", err_cnt - e0, load_busy);
    end
    send_q('{8'hA5, 8'h4B});
    in_valid = 1'b0; idle(3);
    checks++;
    if (err_cnt - e0 != 2 || load_busy !== 1'b0) begin
      failures++; $display("FAIL t3_count75: err=%0d busy=%b required 2 0", err_cnt - e0, load_busy);
    end
    checks++;
    if (wr_cnt != w0) begin failures++; $display("FAIL t3_no_we: got %0d writes required 0", wr_cnt - w0); end
  endtask

  task automatic test_garbage();
    int w0, e0;
    clr_mem(); w0 = wr_cnt; e0 = err_cnt;
    send_q('{8'h00, 8'h12, 8'hA4});
    checks++;
    if (load_busy !== 1'b0) begin failures++; $display("FAIL t4_garbage_busy: got %b required 0", load_busy); end
    send_q('{8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE});
    in_valid = 1'b0;
    wait_done(); idle(2);
    checks++;
    if (wr_cnt - w0 != 74 || err_cnt != e0) begin
      failures++; $display("FAIL t4_counts: writes=%0d err=%0d required 74 0", wr_cnt - w0, err_cnt - e0);
    end
    checks++;
    if ({mem0[0], mem0[1], mem0[2], mem0[73]} !== 32'h10200000) begin
      failures++;
      $display("FAIL t4_data: got %02h %02h %02h %02h required 10 20 00 00", mem0[0], mem0[1], mem0[2], mem0[73]);
    end
    checks++;
    if (active_bank !== 1'b0) begin failures++; $display("FAIL t4_bank: got %b required 0", active_bank); end
  endtask

  task automatic test_timeout();
    int e0;
    clr_mem(); e0 = err_cnt;
    send_q('{8'hA5, 8'h04, 8'h11, 8'h22});
    in_valid = 1'b0;
    idle(1000);
    checks++;
    if (load_busy !== 1'b1 || err_cnt != e0) begin
      failures++; $display("FAIL t5_early: busy=%b err=%0d required 1 0", load_busy, err_cnt - e0);
    end
    idle(30);
    checks++;
    if (load_busy !== 1'b0 || err_cnt - e0 != 1) begin
      failures++; $display("FAIL t5_expired: busy=%b err=%0d required 0 1", load_busy, err_cnt - e0);
    end
    send_q('{8'hA5, 8'h01, 8'h05, 8'hFA});
    in_valid = 1'b0;
    wait_done(); idle(2);
    checks++;
    if ({active_bank, mem1[0], mem1[1], mem1[73]} !== {1'b1, 8'h05, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL t5_reload: bank=%b data=%02h %02h %02h required 1 05 00 00",
               active_bank, mem1[0], mem1[1], mem1[73]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] c1 [0:73];
    logic [7:0] c2 [0:73];
    logic [7:0] s1, s2;
    int w0, e0;
    clr_mem(); w0 = wr_cnt; e0 = err_cnt;
    s1 = 8'd74; s2 = 8'd74;
    for (int i = 0; i < 74; i++) begin
      c1[i] = 8'(i * 3 + 1);
      c2[i] = 8'(i) ^ 8'h5A;
    end
    c1[5] = 8'hA5;
    for (int i = 0; i < 74; i++) begin s1 += c1[i]; s2 += c2[i]; end
    q.push_back(8'hA5); q.push_back(8'd74);
    for (int i = 0; i < 74; i++) q.push_back(c1[i]);
    q.push_back(8'h00 - s1);
    q.push_back(8'hA5); q.push_back(8'd74);
    for (int i = 0; i < 74; i++) q.push_back(c2[i]);
    q.push_back(8'h00 - s2);
    send_q(q);
    in_valid = 1'b0;
    wait_done(); idle(2);
    checks++;
    if (wr_cnt - w0 != 148 || err_cnt != e0) begin
      failures++; $display("FAIL t6_counts: writes=%0d err=%0d required 148 0", wr_cnt - w0, err_cnt - e0);
    end
    checks++;
    if (active_bank !== 1'b1) begin failures++; $display("FAIL t6_bank: got %b required 1", active_bank); end
    for (int i = 0; i < 74; i++) begin
      checks++;
      if (mem0[i] !== c1[i] || mem1[i] !== c2[i]) begin
        failures++;
        $display("FAIL t6_data[%0d]: got %02h/%02h required %02h/%02h", i, mem0[i], mem1[i], c1[i], c2[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    send_q('{8'hA5, 8'h05, 8'h01, 8'h02});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, coef_we, coef_addr, active_bank, coefs_valid, load_busy, load_err} !== 13'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs: ready/we/addr/bank/valid/busy/err=%b/%b/%0d/%b/%b/%b/%b required all 0",
               in_ready, coef_we, coef_addr, active_bank, coefs_valid, load_busy, load_err);
    end
    in_valid = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    checks++;
    if ({in_ready, load_busy, active_bank, coefs_valid} !== 4'b1000) begin
      failures++;
      $display("FAIL mid_reset_release: ready/busy/bank/valid=%b required 1000",
               {in_ready, load_busy, active_bank, coefs_valid});
    end
  endtask

  initial begin
    test_reset();
    test_short_frame();
    test_bad_checksum();
    test_bad_count();
    test_garbage();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
